random_generator: RTL and testbench

RANDOM_GENERATOR -- requirements
Module: random_generator

---
 rtl/rng_pkg.sv | 23 ++
 rtl/rng_lfsr16.sv | 28 ++
 rtl/random_generator.sv | 82 ++++++++
 tb/tb_random_generator.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the 16-bit seeded LFSR random generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rng_pkg;

  // Sequencer states: fetch seed word, load it into the LFSR, then free-run.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } rng_state_t;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] TAP_MASK          = 16'hB400;
  // Seed substituted when the memory word is zero (an all-zero LFSR locks up).
  localparam logic [15:0] DEFAULT_ZERO_SEED = 16'hACE1;

  // XOR of the tapped bits; becomes the new LSB on each shift.
  function automatic logic lfsr_feedback(input logic [15:0] value);
    return ^(value & TAP_MASK);
  endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// Fibonacci LFSR register with a parallel-load mux in front of it.
// Latency: load or shift takes effect on the rising edge after the request.
// Backpressure: none; enable low simply holds the current state.
module rng_lfsr16
  import rng_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);

  // Load takes priority over shifting; reset clears to zero (held until a seed load).
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      state <= '0;
    end else if (load) begin
      state <= load_value;
    end else if (enable) begin
      state <= {state[WIDTH-2:0], lfsr_feedback(state)};
    end
  end

endmodule

// File: rtl/random_generator.sv
// Seeded 16-bit pseudo-random generator: reads its seed from memory, then free-runs an LFSR.
// Latency: first seed on rng_out after the 2nd rising edge following reset release; new value every edge after.
// Backpressure: none; free-running, no stall input. Define RNG_NIBBLE_OUT_EN to drive rng_out_4bit.
module random_generator
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] SEED_ADDR = 16'h0000,
  parameter logic [WIDTH-1:0] ZERO_SEED = DEFAULT_ZERO_SEED
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] rng_out,
  output logic [WIDTH-1:0] rng_out_4bit,
  output logic             internalmux_select
);

  rng_state_t       state;
  rng_state_t       next_state;
  logic             lfsr_load;
  logic             lfsr_en;
  logic [WIDTH-1:0] seed_value;

  // The seed lives at a fixed word, so the address never moves.
  assign address = SEED_ADDR;

  // A zero seed would lock the LFSR at zero forever; swap in a known nonzero one.
  assign seed_value = (mem_data_out == '0) ? ZERO_SEED : mem_data_out;

  // Sequencer state register.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // FETCH waits out the memory read latency, LOAD captures the seed, RUN shifts until reset.
  always_comb begin
    next_state         = state;
    lfsr_load          = 1'b0;
    lfsr_en            = 1'b0;
    internalmux_select = 1'b1;
    case (state)
      FETCH: begin
        next_state = LOAD;
      end
      LOAD: begin
        lfsr_load  = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        internalmux_select = 1'b0;
        lfsr_en            = 1'b1;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  rng_lfsr16 #(
    .WIDTH(WIDTH)
  ) u_lfsr (
    .clock     (clock),
    .nreset    (nreset),
    .load      (lfsr_load),
    .load_value(seed_value),
    .enable    (lfsr_en),
    .state     (rng_out)
  );

`ifdef RNG_NIBBLE_OUT_EN
  assign rng_out_4bit = {{(WIDTH-4){1'b0}}, rng_out[3:0]};
`else
  assign rng_out_4bit = '0;
`endif

endmodule

// File: tb/tb_random_generator.sv
// Self-checking bench for random_generator: random seeds, scoreboard queue, negedge monitor.
// Latency: expectations are queued one per clock cycle and consumed at the following falling edge.
// Backpressure: n/a.
module tb_random_generator;

  localparam logic [15:0] SEED_ADDR = 16'h0000;
  localparam logic [15:0] ZERO_SUB  = 16'hACE1;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic [15:0] mem_data_out;
  logic [15:0] address;
  logic [15:0] rng_out;
  logic [15:0] rng_out_4bit;
  logic        internalmux_select;

  logic [15:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rng;
    logic        mux;
  } exp_t;

  exp_t exp_q[$];

  int          run_idx = 0;
  int          period = 0;
  logic [15:0] first_val = 16'h0;
  bit          zero_seen = 1'b0;

  random_generator #(
    .WIDTH    (16),
    .SEED_ADDR(SEED_ADDR),
    .ZERO_SEED(16'hACE1)
  ) dut (
    .clock             (clock),
    .nreset            (nreset),
    .mem_data_out      (mem_data_out),
    .address           (address),
    .rng_out           (rng_out),
    .rng_out_4bit      (rng_out_4bit),
    .internalmux_select(internalmux_select)
  );

  always #10 clock = ~clock;

  // Companion memory: synchronous read, one-cycle latency, never written by the DUT.
  always @(posedge clock) mem_data_out <= mem[address[3:0]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference step built from the polynomial exponents x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] model_next(input logic [15:0] v);
    int   exps [4];
    logic fb;
    exps = '{16, 14, 13, 11};
    fb = 1'b0;
    foreach (exps[i]) fb = fb ^ v[exps[i]-1];
    return {v[14:0], fb};
  endfunction

  task automatic push(input logic [15:0] rng, input logic mux);
    exp_t e;
    e.rng = rng;
    e.mux = mux;
    exp_q.push_back(e);
  endtask

  // Reset mid-cycle (no clock edge), hold, release, then follow the seed through n RUN steps.
  task automatic run_test(input logic [15:0] seed, input int n);
    logic [15:0] m;
    mem[0] = seed;
    @(posedge clock); #3; nreset = 1'b1; push(16'h0, 1'b1);
    @(posedge clock); #2; push(16'h0, 1'b1);
    @(posedge clock); #2; nreset = 1'b0; push(16'h0, 1'b1);
    @(posedge clock); #2; push(16'h0, 1'b1);
    m = (seed == 16'h0) ? ZERO_SUB : seed;
    @(posedge clock); #2; push(m, 1'b0);
    repeat (n) begin
      @(posedge clock); #2;
      m = model_next(m);
      push(m, 1'b0);
    end
  endtask

  // Monitor: compare outputs against the queued expectation every falling edge; track RUN period.
  initial begin
    exp_t        e;
    logic [15:0] nib;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef RNG_NIBBLE_OUT_EN
        nib = {12'h000, e.rng[3:0]};
`else
        nib = 16'h0000;
`endif
        chk("rng_out", rng_out, e.rng);
        chk("internalmux_select", {15'h0, internalmux_select}, {15'h0, e.mux});
        chk("rng_out_4bit", rng_out_4bit, nib);
        chk("address", address, SEED_ADDR);
      end
      if (internalmux_select === 1'b1) begin
        run_idx = 0;
        period  = 0;
      end else begin
        if (rng_out === 16'h0) zero_seen = 1'b1;
        if (run_idx == 0) first_val = rng_out;
        else if (period == 0 && rng_out === first_val) period = run_idx;
        run_idx++;
      end
    end
  end

  // Stimulus: directed seeds, random seeds, then one full-period run.
  initial begin
    logic [15:0] s;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom()) | 16'h0001;
    run_test(16'hACE1, 20);
    run_test(16'h0000, 20);
    for (int k = 0; k < 4; k++) begin
      s = 16'($urandom_range(0, 65535));
      run_test(s, 25);
    end
    s = 16'($urandom_range(1, 65535));
    run_test(s, 65540);
    @(negedge clock); #1;
    chk("period", 16'(period), 16'd65535);
    chk("never_zero", {15'h0, zero_seen}, 16'h0);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
